// File: rtl/apb_req_pkg.sv
// Shared types and constants for the APB request master.
package apb_req_pkg;

    // Transfer phases of the APB initiator
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_req_state_e;

    localparam int unsigned APB_REQ_TIMEOUT_DEFAULT = 255;

    // Counter width able to hold the timeout limit, never narrower than one bit
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle shared between an initiator and a completer.
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport Master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport Slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_req_timeout.sv
// Saturating wait-state counter that flags when the ACCESS phase has stalled
// for TIMEOUT_CYCLES cycles. A limit of zero never expires.
module apb_req_timeout
    import apb_req_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_REQ_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Count stalled cycles, restarting each transfer and sticking at all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule

// File: rtl/apb_req_master.sv
// Converts a simple req/gnt core request into a single APB3 transfer and
// returns a one-cycle response strobe with read data and error status.
module apb_req_master
    import apb_req_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_REQ_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    APB_BUS.Master                    apb_master
);

    apb_req_state_e r_state;
    apb_req_state_e w_next_state;

    logic                      w_gnt;
    logic                      w_done;
    logic                      w_timeout;
    logic                      w_expired;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_rvalid;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;

    assign w_done    = (r_state == ACCESS) && apb_master.PREADY;
    assign w_timeout = (r_state == ACCESS) && !apb_master.PREADY && w_expired;

    apb_req_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (r_state == SETUP),
        .enable ((r_state == ACCESS) && !apb_master.PREADY),
        .expired(w_expired)
    );

    // Next-state and grant decode; PREADY takes priority over the timeout
    always_comb begin
        w_next_state = r_state;
        w_gnt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_gnt        = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP:   w_next_state = ACCESS;
            ACCESS: begin
                if (w_done || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the request on grant and hold it until the next grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_gnt) begin
            r_paddr  <= addr_i;
            r_pwdata <= wdata_i;
            r_pwrite <= we_i;
        end
    end

    // One-cycle response after completion or timeout; writes return zero data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_done || w_timeout;
            r_err    <= w_done ? apb_master.PSLVERR : w_timeout;
            r_rdata  <= (w_done && !r_pwrite) ? apb_master.PRDATA : '0;
        end
    end

    assign gnt_o              = w_gnt;
    assign rvalid_o           = r_rvalid;
    assign rdata_o            = r_rdata;
    assign err_o              = r_err;
    assign apb_master.PADDR   = r_paddr;
    assign apb_master.PWDATA  = r_pwdata;
    assign apb_master.PWRITE  = r_pwrite;
    assign apb_master.PSEL    = (r_state != IDLE);
    assign apb_master.PENABLE = (r_state == ACCESS);

endmodule

// File: tb/tb_apb_req_master.sv
// Cycle-by-cycle directed bench for apb_req_master with a short timeout so
// the stall abort and the PREADY-wins race can be exercised quickly.
module tb_apb_req_master;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
        logic        gnt;
        logic        psel;
        logic        pen;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int nTests = 0;
    int nFail  = 0;

    vec_t        vecs[$];
    logic [31:0] eAddr;
    logic [31:0] eData;
    logic        eWr;

    APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apbBus ();

    apb_req_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .apb_master(apbBus)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds one cycle record; the expected bus contents come from eAddr/eData/eWr
    function automatic vec_t row(input logic rq, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic rdy, input logic [31:0] prd,
                                 input logic slverr, input logic xg, input logic xs,
                                 input logic xe, input logic xv, input logic [31:0] xd,
                                 input logic xerr);
        vec_t v;
        v = '{req: rq, we: w, addr: a, wdata: wd, pready: rdy, prdata: prd, pslverr: slverr,
              gnt: xg, psel: xs, pen: xe, rvalid: xv, rdata: xd, err: xerr,
              paddr: eAddr, pwdata: eData, pwrite: eWr};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        req            = v.req;
        we             = v.we;
        addr           = v.addr;
        wdata          = v.wdata;
        apbBus.PREADY  = v.pready;
        apbBus.PRDATA  = v.prdata;
        apbBus.PSLVERR = v.pslverr;
    endtask

    task automatic checkOutput(input string tag, input int idx,
                               input logic [95:0] act, input logic [95:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h", tag, idx, act, exp);
        end
    endtask

    task automatic idleRow();
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Fills the vector table, runs it, then the reset-abort sequence
    initial begin
        eAddr = '0; eData = '0; eWr = 1'b0;

        // Zero-wait read
        vecs.push_back(row(1, 0, 32'h1A10_0008, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h1A10_0008; eData = 32'h0; eWr = 1'b0;
        vecs.push_back(row(0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0));
        idleRow();

        // Write with three wait states; PRDATA must not leak into rdata
        vecs.push_back(row(1, 1, 32'h1A10_0010, 32'h0000_00A5, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h1A10_0010; eData = 32'h0000_00A5; eWr = 1'b1;
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        idleRow();

        // Read completing with PSLVERR
        vecs.push_back(row(1, 0, 32'h1A10_0020, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h1A10_0020; eData = 32'h0; eWr = 1'b0;
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1));
        idleRow();

        // Back-to-back reads with req held high; second grant rides on the first rvalid
        vecs.push_back(row(1, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h100; eData = 32'h0; eWr = 1'b0;
        vecs.push_back(row(1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 0, 32'h100, 0, 1, 32'h1111_1111, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(1, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0, 1, 32'h1111_1111, 0));
        eAddr = 32'h200;
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 1, 32'h2222_2222, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222, 0));
        idleRow();

        // Timeout: counter reads 0..4 over five stalled ACCESS cycles, abort on the fifth
        vecs.push_back(row(1, 0, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h300; eData = 32'h0; eWr = 1'b0;
        vecs.push_back(row(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(row(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'h0, 1));
        idleRow();

        // PREADY arrives in the very cycle the timeout would fire and wins
        vecs.push_back(row(1, 0, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        eAddr = 32'h400; eData = 32'h0; eWr = 1'b0;
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 1, 32'hABCD_0123, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD_0123, 0));
        idleRow();

        // Reset state
        rst = 1'b1;
        applyStimulus('0);
        #12;
        checkOutput("reset_ctrl", 0, {gnt, apbBus.PSEL, apbBus.PENABLE, rvalid, err, rdata}, 96'h0);
        checkOutput("reset_bus", 0, {apbBus.PADDR, apbBus.PWDATA, apbBus.PWRITE}, 96'h0);

        // Release reset; the first row's grant lands on the first edge without reset
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput("ctrl", i, {gnt, apbBus.PSEL, apbBus.PENABLE, rvalid},
                        {vecs[i].gnt, vecs[i].psel, vecs[i].pen, vecs[i].rvalid});
            if (vecs[i].rvalid) begin
                checkOutput("resp", i, {err, rdata}, {vecs[i].err, vecs[i].rdata});
            end
            checkOutput("bus", i, {apbBus.PADDR, apbBus.PWDATA, apbBus.PWRITE},
                        {vecs[i].paddr, vecs[i].pwdata, vecs[i].pwrite});
        end

        // Reset in the middle of ACCESS aborts the transfer without a response
        @(posedge clk); #1;
        applyStimulus(row(1, 1, 32'h500, 32'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("rst_gnt", 0, {31'h0, gnt}, 32'h1);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_access", 0, {apbBus.PSEL, apbBus.PENABLE}, 2'b11);
        #6;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 0, {apbBus.PSEL, apbBus.PENABLE, rvalid, apbBus.PADDR}, 35'h0);
        @(posedge clk); #1;
        checkOutput("rst_held", 0, {apbBus.PSEL, rvalid}, 2'b00);
        rst = 1'b0;
        applyStimulus(row(1, 0, 32'h600, 0, 1, 32'h600D_600D, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("rst_regnt", 0, {gnt, rvalid}, 2'b10);
        @(posedge clk); #1;
        req = 1'b0;
        checkOutput("rst_setup", 0, {apbBus.PSEL, apbBus.PENABLE, rvalid, apbBus.PADDR},
                    {3'b100, 32'h600});
        @(posedge clk); #1;
        checkOutput("rst_access2", 0, {apbBus.PSEL, apbBus.PENABLE, rvalid}, 3'b110);
        @(posedge clk); #1;
        checkOutput("rst_resp", 0, {rvalid, err, rdata}, {2'b10, 32'h600D_600D});

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
